// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame sequencer.
//
// Accepts one byte per data_valid/busy handshake and latches the byte and its
// parity settings. It then sends a start bit, eight data bits LSB-first, an
// optional parity bit and STOP_BITS stop bits, each lasting CLKS_PER_BIT
// clocks.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   data_in      byte to send, sampled at accept
//   data_valid   request; accepted when data_valid && !busy
//   parity_en    1 = insert parity bit, sampled at accept
//   parity_type  0 = even, 1 = odd, sampled at accept
//   busy         high from the accept edge until the frame completes
//   tx           registered serial line, idle high
//   done         one-cycle pulse at frame completion
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             stop_idx, stop_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par_en, par_en_nxt;
  logic             par_bit, par_bit_nxt;
  logic             tx_nxt, busy_nxt, done_nxt;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      shreg    <= shreg_nxt;
      par_en   <= par_en_nxt;
      par_bit  <= par_bit_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // tx/busy/done are computed one cycle ahead so the registered outputs
  // change on the same edge as the state they belong to.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    par_en_nxt   = par_en;
    par_bit_nxt  = par_bit;
    tx_nxt       = tx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        // busy is always low in IDLE, so data_valid alone means accept
        if (data_valid) begin
          state_nxt   = START;
          shreg_nxt   = data_in;
          par_en_nxt  = parity_en;
          par_bit_nxt = parity_bit(data_in, parity_type);
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          tx_nxt      = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            if (par_en) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt    = STOP;
              stop_idx_nxt = 1'b0;
              tx_nxt       = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = shreg >> 1;
            // next bit to drive is the one about to land in bit 0
            tx_nxt      = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt    = STOP;
          cnt_nxt      = '0;
          stop_idx_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          cnt_nxt = '0;
          if (stop_idx == STOP_LAST) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit frame sequencer. It accepts one byte per handshake and latches the byte and the parity configuration. It then drives the serial line with a start bit, eight data bits LSB-first, an optional parity bit and one or two stop bits, each bit timed by an internal baud counter. It sits between the byte source (FIFO or host register) and the `tx` pin, and it owns the parity bit that goes into the frame.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal values are ≥ 2.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

Clock is `clk`. Reset is `rst`: synchronous and active-high.

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `data_in`  in  8  byte to transmit; sampled at accept
- `data_valid`  in  1  request; accepted when `data_valid && !busy` at a rising edge
- `parity_en`  in  1  1 = insert parity bit; sampled at accept
- `parity_type`  in  1  0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data); sampled at accept
- `busy`  out  1  high from the accept edge until the frame completes
- `tx`  out  1  serial line; idle high; registered output
- `done`  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and clears on every state or bit change. A bit ends when the counter reaches CLKS_PER_BIT-1.
- IDLE:
  - `tx`=1, `busy`=0.
  - On accept, latch `data_in` into a shift register and latch `parity_en` and `parity_type`.
  - Compute the parity bit from the latched byte at accept.
  - Go to START.
- START: `tx`=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift register bit 0; shift right at each bit end.
  - The bit index is a 3-bit counter.
  - After index 7 completes, go to PARITY if the latched `parity_en`=1, otherwise go to STOP.
- PARITY: `tx` = latched parity bit for one bit time, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS bit times.
  - At the end, go to IDLE with `busy`=0 and `done`=1 for that one cycle.
- Changes to `data_in`, `parity_en` or `parity_type` while `busy`=1 have no effect on the frame in flight.
- `data_valid` while `busy`=1 is ignored. There is no queuing; the requester holds `data_valid` until it sees `busy` fall.
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, counters 0, shift register 0.

## Timing
- Let C = CLKS_PER_BIT, P = parity_en (0/1), S = STOP_BITS, and T0 = the accept edge.
- At T0: `busy`=1 and `tx`=0. The start bit occupies cycles T0..T0+C-1.
- Data bit i is driven from edge T0+(1+i)·C for C cycles, i = 0..7.
- The parity bit, when enabled, is driven from edge T0+9C.
- The stop bit(s) are driven from edge T0+(9+P)·C for S·C cycles.
- At edge T0+(9+P+S)·C: `busy`=0 and `done`=1 for exactly one cycle; `tx` stays 1.
- Frame length is (10+P+S-1)·C cycles, i.e. (9+P+S)·C.
- Back-to-back: `data_valid` sampled on the `done` edge sees `busy`=1 and is not accepted. The earliest next accept is the edge after `done`, which gives a minimum idle gap of one clock at `tx`=1.
- Reset mid-frame: at the first edge with `rst`=1, `tx`=1, `busy`=0 and `done`=0 immediately. The frame is abandoned with no completion pulse.
- `rst` and `data_valid` asserted together: reset wins and nothing is accepted.
- `done` and `busy` never go high in the same cycle.

## Test plan
Parameters for all scenarios are C=4, S=1 unless stated.

- Byte 0xA5, even parity (`parity_en`=1, `parity_type`=0):
  - Accept → `tx` holds 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - The parity bit is 0 (the byte has four 1s).
  - Then stop=1 for 4 cycles; `done` pulses at T0+44; `busy` is high for exactly 44 cycles.
- Byte 0xA5, odd parity: identical to the even case except the parity bit is 1.
- Byte 0x01, no parity (`parity_en`=0): the frame is 0,1,0,0,0,0,0,0,0,1, `done` pulses at T0+40, and there is no parity slot.
- Byte 0x3C with S=2, even parity: stop=1 for 8 cycles and `done` pulses at T0+48.
  - Toggling `data_in`, `parity_type` and `parity_en` mid-frame does not change the `tx` sequence.
- `data_valid` held high continuously with bytes 0x55 then 0xAA:
  - The second byte is accepted on the edge after `done`.
  - `tx` is high for exactly 1 cycle between frames.
  - Pulsing `data_valid` during a frame produces no extra frame.
- Assert `rst` for 1 cycle during DATA bit 3 → next edge `tx`=1, `busy`=0, `done` never pulses.
  - A new accept afterwards produces a clean full frame.
